// File: rtl/tpg_pkg.sv
// Shared types for the raster test-pattern generator: pattern select, FSM states,
// timing-vector slot indices and the colour-bar mask table.
package tpg_pkg;

   typedef enum logic [1:0] {
      PAT_RAMP    = 2'd0,
      PAT_BARS    = 2'd1,
      PAT_CHECKER = 2'd2,
      PAT_SOLID   = 2'd3
   } pat_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   // Slot order inside a per-axis timing vector
   localparam int T_SYNC_START = 0;
   localparam int T_SYNC_END   = 1;
   localparam int T_ACT_START  = 2;
   localparam int T_ACT_END    = 3;
   localparam int T_END        = 4;

   // {R,G,B} masks; entry 0 (rightmost) is white, then Y,C,G,M,R,B,K
   localparam logic [7:0][2:0] BAR_TBL = {3'b000, 3'b001, 3'b100, 3'b101,
                                          3'b010, 3'b011, 3'b110, 3'b111};

endpackage

// File: rtl/tpg_raster_gen_if.sv
// Video output bus of the test-pattern generator (sync, data enable, markers, pixel).
interface tpg_raster_gen_if #(parameter int PW = 8);
   logic            hs_q;
   logic            vs_q;
   logic            vld_q;
   logic            sof_q;
   logic            eol_q;
   logic [3*PW-1:0] rgb;

   modport master (output hs_q, vs_q, vld_q, sof_q, eol_q, rgb);
   modport slave  (input  hs_q, vs_q, vld_q, sof_q, eol_q, rgb);
endinterface

// File: rtl/tpg_raster_cnt.sv
// Raster counters, IDLE/RUN control and frame-shadowed timing; produces unregistered
// hs/vs/de/sof/eol and active-area coordinates. Frame counter under TPG_FRAME_ANIM_EN.
module tpg_raster_cnt
   import tpg_pkg::*;
#(
   parameter int H_BITS = 12,
   parameter int V_BITS = 12
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   enable,
   input  pat_e                   patSel,
   input  logic [4:0][H_BITS-1:0] hTim,
   input  logic [4:0][V_BITS-1:0] vTim,
`ifdef TPG_FRAME_ANIM_EN
   output logic [15:0]            frameCnt,
`endif
   output pat_e                   patSh,
   output logic [H_BITS-1:0]      xa,
   output logic [V_BITS-1:0]      ya,
   output logic                   hs,
   output logic                   vs,
   output logic                   de,
   output logic                   sof,
   output logic                   eol
);

   state_e                  state, stateNxt;
   logic                    load, run, frameEnd;
   logic [H_BITS-1:0]       x;
   logic [V_BITS-1:0]       y;
   logic [4:0][H_BITS-1:0]  hSh;
   logic [4:0][V_BITS-1:0]  vSh;

   assign run      = (state == ST_RUN);
   assign frameEnd = run && (x == hSh[T_END]) && (y == vSh[T_END]);

   always_comb begin
      stateNxt = state;
      load     = 1'b0;
      case (state)
         ST_IDLE: if (enable) begin
            stateNxt = ST_RUN;
            load     = 1'b1;
         end
         ST_RUN: if (frameEnd) begin
            if (enable) load = 1'b1;
            else        stateNxt = ST_IDLE;
         end
         default: stateNxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= ST_IDLE;
      else        state <= stateNxt;

   // Timing and pattern only change on frame boundaries so a frame is never torn
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         hSh   <= '0;
         vSh   <= '0;
         patSh <= PAT_RAMP;
      end else if (load) begin
         hSh   <= hTim;
         vSh   <= vTim;
         patSh <= patSel;
      end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         x <= '0;
         y <= '0;
      end else if (!run || frameEnd) begin
         x <= '0;
         y <= '0;
      end else if (x == hSh[T_END]) begin
         x <= '0;
         y <= y + V_BITS'(1);
      end else begin
         x <= x + H_BITS'(1);
      end

`ifdef TPG_FRAME_ANIM_EN
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)        frameCnt <= '0;
      else if (frameEnd) frameCnt <= frameCnt + 16'd1;
`endif

   assign hs  = run && (x >= hSh[T_SYNC_START]) && (x < hSh[T_SYNC_END]);
   assign vs  = run && (y >= vSh[T_SYNC_START]) && (y < vSh[T_SYNC_END]);
   assign de  = run && (x >= hSh[T_ACT_START]) && (x < hSh[T_ACT_END])
                    && (y >= vSh[T_ACT_START]) && (y < vSh[T_ACT_END]);
   assign xa  = x - hSh[T_ACT_START];
   assign ya  = y - vSh[T_ACT_START];
   assign sof = de && (xa == '0) && (ya == '0);
   assign eol = de && (x == hSh[T_ACT_END] - H_BITS'(1));

endmodule

// File: rtl/tpg_raster_gen.sv
// Video timing + test-pattern generator top: pattern mux and output register stage.
// Optional TPG_FRAME_ANIM_EN adds frame_cnt_q and frame-animated RAMP/CHECKER.
module tpg_raster_gen
   import tpg_pkg::*;
#(
   parameter int PW        = 8,
   parameter int H_BITS    = 12,
   parameter int V_BITS    = 12,
   parameter int BAR_SHIFT = 5,
   parameter int CHK_SHIFT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic [1:0]        pat_sel,
   input  logic [3*PW-1:0]   solid_rgb,
   input  logic [H_BITS-1:0] tHS_START,
   input  logic [H_BITS-1:0] tHS_END,
   input  logic [H_BITS-1:0] tHACT_START,
   input  logic [H_BITS-1:0] tHACT_END,
   input  logic [H_BITS-1:0] tH_END,
   input  logic [V_BITS-1:0] tVS_START,
   input  logic [V_BITS-1:0] tVS_END,
   input  logic [V_BITS-1:0] tVACT_START,
   input  logic [V_BITS-1:0] tVACT_END,
   input  logic [V_BITS-1:0] tV_END,
`ifdef TPG_FRAME_ANIM_EN
   output logic [15:0]       frame_cnt_q,
`endif
   tpg_raster_gen_if.master  vid
);

   localparam int WMAX = (H_BITS > V_BITS) ? H_BITS : V_BITS;

   pat_e              patSh;
   logic [H_BITS-1:0] xa;
   logic [V_BITS-1:0] ya;
   logic              hs, vs, de, sof, eol, chk;
   logic [WMAX-1:0]   xw, yw;
   logic [PW-1:0]     ramp;
   logic [2:0]        bar;
   logic [3*PW-1:0]   rgbNxt;
`ifdef TPG_FRAME_ANIM_EN
   logic [15:0]       frameCnt;
   assign frame_cnt_q = frameCnt;
`endif

   tpg_raster_cnt #(.H_BITS(H_BITS), .V_BITS(V_BITS)) uCnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .enable   (enable),
      .patSel   (pat_e'(pat_sel)),
      .hTim     ({tH_END, tHACT_END, tHACT_START, tHS_END, tHS_START}),
      .vTim     ({tV_END, tVACT_END, tVACT_START, tVS_END, tVS_START}),
`ifdef TPG_FRAME_ANIM_EN
      .frameCnt (frameCnt),
`endif
      .patSh    (patSh),
      .xa       (xa),
      .ya       (ya),
      .hs       (hs),
      .vs       (vs),
      .de       (de),
      .sof      (sof),
      .eol      (eol)
   );

   assign xw  = WMAX'(xa);
   assign yw  = WMAX'(ya);
   assign bar = BAR_TBL[3'(xa >> BAR_SHIFT)];

   always_comb begin
`ifdef TPG_FRAME_ANIM_EN
      ramp = PW'(xa) + PW'(frameCnt);
      chk  = ((((xw ^ yw) >> CHK_SHIFT) & WMAX'(1)) != '0) ^ frameCnt[0];
`else
      ramp = PW'(xa);
      chk  = (((xw ^ yw) >> CHK_SHIFT) & WMAX'(1)) != '0;
`endif
      case (patSh)
         PAT_RAMP:    rgbNxt = {ramp, ramp, ramp};
         PAT_BARS:    rgbNxt = {{PW{bar[2]}}, {PW{bar[1]}}, {PW{bar[0]}}};
         PAT_CHECKER: rgbNxt = {(3*PW){chk}};
         default:     rgbNxt = solid_rgb;
      endcase
      if (!de) rgbNxt = '0;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         vid.hs_q  <= 1'b0;
         vid.vs_q  <= 1'b0;
         vid.vld_q <= 1'b0;
         vid.sof_q <= 1'b0;
         vid.eol_q <= 1'b0;
         vid.rgb   <= '0;
      end else begin
         vid.hs_q  <= hs;
         vid.vs_q  <= vs;
         vid.vld_q <= de;
         vid.sof_q <= sof;
         vid.eol_q <= eol;
         vid.rgb   <= rgbNxt;
      end

endmodule
